// File: rtl/tdm_mux_pkg.sv
// -----------------------------------------------------------------------------
// tdm_mux_pkg
//
// Shared definitions for the N-channel time-division multiplexer.
//
// Contents:
//   MODE_MANUAL / MODE_SCAN : encodings of the 'mode' input
//   next_idx()              : next channel index with wrap at nch-1 -> 0
// -----------------------------------------------------------------------------
package tdm_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Round-robin successor of idx in a ring of nch channels. Indices at or
  // beyond the last channel also wrap to 0, so a corrupted pointer recovers.
  function automatic int next_idx(input int idx, input int nch);
    return (idx >= nch - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tdm_mux_ptr.sv
// -----------------------------------------------------------------------------
// tdm_mux_ptr
//
// Round-robin scan pointer for tdm_mux. Holds the pointer register and the
// registered previous mode used to detect entry into scan mode.
//
// Configuration macro: TDM_MUX_SKIP_EN
//   undefined : pointer advances only when its channel transfers a word
//               (strict TDM slotting, the slot waits for its channel)
//   defined   : pointer also steps past an idle channel whenever the output
//               register could have loaded, one channel per cycle
//
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  synchronous active-low reset
//   mode       in  0 = manual, 1 = scan
//   ld         in  output register is free or draining this cycle
//   cur_valid  in  in_valid of the channel the pointer currently selects
//   ptr        out effective pointer for this cycle (0 on scan entry)
// -----------------------------------------------------------------------------
module tdm_mux_ptr
  import tdm_mux_pkg::*;
#(
  parameter int NCH  = 16,
  parameter int SELW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic            ld,
  input  logic            cur_valid,
  output logic [SELW-1:0] ptr
);

`ifdef TDM_MUX_SKIP_EN
  localparam logic SKIP_EN = 1'b1;
`else
  localparam logic SKIP_EN = 1'b0;
`endif

  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] ptr_d;
  logic            mode_q;
  logic            mode_d;
  logic            entry;
  logic [SELW-1:0] base;
  logic            advance;

  // On the first scan cycle after manual mode the pointer restarts at 0 in
  // the same cycle, so the top level already selects channel 0 while the
  // register is being rewritten.
  always_comb begin
    entry = (mode == MODE_SCAN) && (mode_q == MODE_MANUAL);
    base  = entry ? '0 : ptr_q;
    ptr   = base;
  end

  // In scan mode the selected channel is always in range, so a transfer is
  // simply ld with a valid channel. The skip build steps on any ld cycle,
  // which covers both the transfer and the idle-channel case.
  always_comb begin
    ptr_d   = ptr_q;
    mode_d  = mode;
    advance = ld && (cur_valid || SKIP_EN);
    if (mode == MODE_SCAN) begin
      ptr_d = advance ? SELW'(next_idx(int'(base), NCH)) : base;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      mode_q <= MODE_MANUAL;
    end else begin
      ptr_q  <= ptr_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/tdm_mux.sv
// -----------------------------------------------------------------------------
// tdm_mux
//
// Parametrised N-channel, DW-bit time-division multiplexer with a registered
// output and valid/ready flow control on both sides. In manual mode the
// external select picks the channel; in scan mode an internal round-robin
// pointer (tdm_mux_ptr) does.
//
// Configuration macro: TDM_MUX_SKIP_EN (see tdm_mux_ptr) enables skipping of
// idle channels in scan mode. Manual mode is unaffected by it.
//
// Parameters:
//   NCH   number of input channels (>= 2)
//   DW    data width per channel
//   SELW  width of select / channel index
//
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  synchronous active-low reset
//   mode       in  0 = manual select, 1 = round-robin scan
//   sel        in  manual channel select (mode = 0 only)
//   in_data    in  packed channel data, channel i at [i*DW +: DW]
//   in_valid   in  per-channel valid
//   in_ready   out per-channel ready, one-hot or zero
//   out_data   out registered selected data
//   out_ch     out channel index of the word in out_data
//   out_valid  out out_data/out_ch hold a word
//   out_ready  in  downstream accepts the word
//   sel_err    out one-cycle pulse: manual sel >= NCH while a load was possible
// -----------------------------------------------------------------------------
module tdm_mux
  import tdm_mux_pkg::*;
#(
  parameter int NCH  = 16,
  parameter int DW   = 8,
  parameter int SELW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [DW-1:0]     out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err
);

  logic [DW-1:0]   out_data_q;
  logic [DW-1:0]   out_data_d;
  logic [SELW-1:0] out_ch_q;
  logic [SELW-1:0] out_ch_d;
  logic            out_valid_q;
  logic            out_valid_d;
  logic            sel_err_q;
  logic            sel_err_d;

  logic [SELW-1:0] cur;
  logic [SELW-1:0] cur_ptr;
  logic            cur_ok;
  logic            cur_valid;
  logic [DW-1:0]   cur_data;
  logic            ld;
  logic            xfer;

  tdm_mux_ptr #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .ld        (ld),
    .cur_valid (cur_valid),
    .ptr       (cur_ptr)
  );

  // Channel selection and load enable. A mode change takes effect in the
  // same cycle because cur is purely combinational from mode.
  always_comb begin
    cur = (mode == MODE_SCAN) ? cur_ptr : sel;
    ld  = !out_valid_q || out_ready;
  end

  // An out-of-range index is only reachable when NCH is not a power of two;
  // otherwise every encodable index names a real channel.
  generate
    if (NCH == (1 << SELW)) begin : g_pow2
      assign cur_ok = 1'b1;
    end else begin : g_npow2
      assign cur_ok = (cur < SELW'(NCH));
    end
  endgenerate

  // Explicit compare-and-pick instead of a variable part-select so that an
  // out-of-range index yields zero rather than an undefined slice.
  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    in_ready  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cur == SELW'(i)) begin
        cur_valid   = in_valid[i];
        cur_data    = in_data[i*DW +: DW];
        in_ready[i] = rst_n && ld;
      end
    end
  end

  // Output register: load on a transfer, empty on an unused load slot, hold
  // while stalled. Draining and reloading in one cycle keeps full throughput.
  always_comb begin
    xfer        = rst_n && ld && cur_ok && cur_valid;
    sel_err_d   = ld && (mode == MODE_MANUAL) && !cur_ok;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = cur_data;
      out_ch_d    = cur;
      out_valid_d = 1'b1;
    end else if (ld) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_tdm_mux.sv
// -----------------------------------------------------------------------------
// tb_tdm_mux
//
// Scoreboard bench for tdm_mux. A 16-channel instance is driven by directed
// and random stimulus; a behavioural model predicts in_ready, out_valid,
// sel_err and the words that must appear, queueing each accepted word. A
// separate monitor compares the DUT against those predictions every cycle
// and pops the queue whenever the DUT hands a word downstream. A second,
// 12-channel instance exercises the out-of-range manual select.
// -----------------------------------------------------------------------------
module tb_tdm_mux;

  localparam int NCH = 16;
  localparam int DW  = 8;

`ifdef TDM_MUX_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    int ch;
    int data;
  } word_t;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic [3:0]   sel;
  logic [127:0] in_data;
  logic [15:0]  in_valid;
  logic [15:0]  in_ready;
  logic [7:0]   out_data;
  logic [3:0]   out_ch;
  logic         out_valid;
  logic         out_ready;
  logic         sel_err;

  logic         mode12;
  logic [3:0]   sel12;
  logic [95:0]  in_data12;
  logic [11:0]  in_valid12;
  logic [11:0]  in_ready12;
  logic [7:0]   out_data12;
  logic [3:0]   out_ch12;
  logic         out_valid12;
  logic         out_ready12;
  logic         sel_err12;

  int checks = 0;
  int errors = 0;

  word_t       sb[$];
  bit          m_valid;
  bit          m_sel_err;
  bit          m_mode_prev;
  int          m_ptr;
  logic [15:0] exp_in_ready;
  bit          exp_out_valid;
  bit          exp_sel_err;

  tdm_mux #(.NCH(NCH), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  tdm_mux #(.NCH(12), .DW(DW)) dut12 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode12),
    .sel       (sel12),
    .in_data   (in_data12),
    .in_valid  (in_valid12),
    .in_ready  (in_ready12),
    .out_data  (out_data12),
    .out_ch    (out_ch12),
    .out_valid (out_valid12),
    .out_ready (out_ready12),
    .sel_err   (sel_err12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ramp_data();
    logic [127:0] d;
    for (int i = 0; i < NCH; i++) d[i*8 +: 8] = 8'(i + 8'h10);
    return d;
  endfunction

  function automatic logic [127:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle of inputs at the falling edge and advance the reference
  // model by one clock. The model works on channel numbers and a word queue:
  // a free output takes the chosen channel if it is valid, scan mode walks
  // the ring, and entering scan mode restarts at channel 0.
  task automatic applyStimulus(input bit rst, input bit md, input int s, input logic [15:0] v,
                               input logic [127:0] d, input bit ordy);
    bit free;
    bit take;
    int chan;
    @(negedge clk);
    rst_n     = !rst;
    mode      = md;
    sel       = 4'(s);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    exp_out_valid = m_valid;
    exp_sel_err   = m_sel_err;
    if (rst) begin
      exp_in_ready = '0;
      sb.delete();
      m_valid     = 0;
      m_sel_err   = 0;
      m_ptr       = 0;
      m_mode_prev = 0;
    end else begin
      free = !m_valid || ordy;
      if (md && !m_mode_prev) m_ptr = 0;
      chan = md ? m_ptr : s;
      exp_in_ready = (free && chan < NCH) ? (16'h1 << chan) : 16'h0;
      take = free && (chan < NCH) && v[chan];
      m_sel_err = free && !md && (chan >= NCH);
      if (take) begin
        sb.push_back('{chan, int'(d[chan*8 +: 8])});
        m_valid = 1;
      end else if (free) begin
        m_valid = 0;
      end
      if (md && (take || (SKIP && free && !v[chan]))) m_ptr = (m_ptr + 1) % NCH;
      m_mode_prev = md;
    end
  endtask

  // Monitor: just before each rising edge compare the handshake outputs and,
  // when a word is handed downstream, the oldest queued expectation.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      #4;
      checkOutput("in_ready", in_ready, exp_in_ready);
      checkOutput("out_valid", out_valid, exp_out_valid);
      checkOutput("sel_err", sel_err, exp_sel_err);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected_word actual=ch%0d/%0h expected=none", out_ch, out_data);
        end else begin
          w = sb.pop_front();
          checkOutput("sb_out_ch", out_ch, w.ch);
          checkOutput("sb_out_data", out_data, w.data);
        end
      end
    end
  end

  initial begin
    logic [127:0] d;
    rst_n = 0; mode = 0; sel = 0; in_data = '0; in_valid = '0; out_ready = 0;
    mode12 = 0; sel12 = 0; in_data12 = '0; in_valid12 = '0; out_ready12 = 1;
    m_valid = 0; m_sel_err = 0; m_mode_prev = 0; m_ptr = 0;
    exp_in_ready = '0; exp_out_valid = 0; exp_sel_err = 0;

    // Reset and reset state
    applyStimulus(1, 0, 0, 16'h0, '0, 1);
    applyStimulus(1, 0, 0, 16'h0, '0, 1);
    applyStimulus(0, 0, 0, 16'h0, '0, 1);
    #4;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_ch", out_ch, 0);
    checkOutput("rst_sel_err", sel_err, 0);

    // Manual select of channel 5
    d = '0; d[5*8 +: 8] = 8'hA5;
    applyStimulus(0, 0, 5, 16'h0020, d, 1);
    #4;
    checkOutput("man_in_ready", in_ready, 16'h0020);
    applyStimulus(0, 0, 5, 16'h0000, d, 1);
    #4;
    checkOutput("man_out_valid", out_valid, 1);
    checkOutput("man_out_data", out_data, 8'hA5);
    checkOutput("man_out_ch", out_ch, 5);

    // Stall for three cycles, then drain and reload in the same cycle
    d = '0; d[2*8 +: 8] = 8'h22;
    applyStimulus(0, 0, 2, 16'h0004, d, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 2, 16'hFFFF, rand_data(), 0);
      #4;
      checkOutput("stall_out_data", out_data, 8'h22);
      checkOutput("stall_in_ready", in_ready, 16'h0);
    end
    d = '0; d[2*8 +: 8] = 8'h77;
    applyStimulus(0, 0, 2, 16'h0004, d, 1);
    #4;
    checkOutput("b2b_in_ready", in_ready, 16'h0004);
    applyStimulus(0, 0, 2, 16'h0000, d, 1);
    #4;
    checkOutput("b2b_out_data", out_data, 8'h77);
    checkOutput("b2b_out_valid", out_valid, 1);

    // Scan, all channels valid: 0..15,0 on consecutive cycles
    for (int k = 0; k <= 17; k++) begin
      applyStimulus(0, 1, 0, 16'hFFFF, ramp_data(), 1);
      #4;
      if (k > 0) begin
        checkOutput("scan_out_ch", out_ch, (k - 1) % NCH);
        checkOutput("scan_out_data", out_data, 8'h10 + ((k - 1) % NCH));
      end
    end

    // Scan with only channels 0 and 3 active
    for (int k = 0; k < 12; k++) applyStimulus(0, 1, 0, 16'h0009, ramp_data(), 1);

    // Out-of-range manual select on the 12-channel instance
    applyStimulus(0, 0, 0, 16'h0, '0, 1);
    in_data12 = '0; in_data12[11*8 +: 8] = 8'hC3;
    sel12 = 4'd13; in_valid12 = 12'hFFF; mode12 = 0; out_ready12 = 1;
    #4;
    checkOutput("oor_in_ready", in_ready12, 12'h000);
    applyStimulus(0, 0, 0, 16'h0, '0, 1);
    sel12 = 4'd11;
    #4;
    checkOutput("oor_sel_err", sel_err12, 1);
    checkOutput("oor_out_valid", out_valid12, 0);
    checkOutput("ch11_in_ready", in_ready12, 12'h800);
    applyStimulus(0, 0, 0, 16'h0, '0, 1);
    in_valid12 = '0;
    #4;
    checkOutput("ch11_sel_err", sel_err12, 0);
    checkOutput("ch11_out_valid", out_valid12, 1);
    checkOutput("ch11_out_ch", out_ch12, 11);
    checkOutput("ch11_out_data", out_data12, 8'hC3);

    // Mode 1 -> 0 -> 1: scan restarts at channel 0
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 16'hFFFF, ramp_data(), 1);
    for (int k = 0; k < 2; k++) applyStimulus(0, 0, 7, 16'hFFFF, ramp_data(), 1);
    applyStimulus(0, 1, 0, 16'hFFFF, ramp_data(), 1);
    applyStimulus(0, 1, 0, 16'hFFFF, ramp_data(), 1);
    #4;
    checkOutput("reentry_out_ch", out_ch, 0);

    // Reset in the middle of a stalled scan stream
    applyStimulus(0, 1, 0, 16'hFFFF, ramp_data(), 0);
    applyStimulus(1, 1, 0, 16'hFFFF, ramp_data(), 0);
    applyStimulus(0, 1, 0, 16'hFFFF, ramp_data(), 1);
    #4;
    checkOutput("midrst_out_valid", out_valid, 0);
    applyStimulus(0, 1, 0, 16'h0000, ramp_data(), 1);
    #4;
    checkOutput("midrst_out_ch", out_ch, 0);
    checkOutput("midrst_out_data", out_data, 8'h10);

    // Randomised traffic with occasional mode flips and resets
    begin
      bit md;
      md = 1;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(7) == 0) md = !md;
        applyStimulus($urandom_range(199) == 0, md, $urandom_range(15),
                      16'($urandom), rand_data(), $urandom_range(3) != 0);
      end
    end

    // Drain and confirm nothing was left undelivered
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 16'h0, '0, 1);
    #6;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain actual=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_mux.md
Name: tdm_mux

Overview:
Parametrised N-channel, multi-bit time-division multiplexer with a registered output and valid/ready flow control. It is the successor to the fixed 16:1 single-bit combinational mux. Two modes:
- Manual: an external select picks the channel.
- Scan: an internal pointer rotates round-robin through the channels.
It sits between per-channel sources and a single shared downstream consumer.

Parameters:
NCH, 16, number of input channels (>=2)
DW, 8, data width per channel
SELW, $clog2(NCH), width of select/channel index

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
mode  input  1  0 = manual select, 1 = round-robin scan
sel  input  SELW  manual channel select; used only when mode=0
in_data  input  NCH*DW  packed channel data; channel i at [i*DW +: DW]
in_valid  input  NCH  per-channel valid
in_ready  output  NCH  per-channel ready, one-hot or zero
out_data  output  DW  registered selected data
out_ch  output  SELW  channel index of the word in out_data
out_valid  output  1  out_data/out_ch hold a word
out_ready  input  1  downstream accepts word
sel_err  output  1  one-cycle pulse: manual sel >= NCH while a load was possible

Behaviour:
- One clock domain. Reset is synchronous, active-low, sampled on the clk rising edge.
- Reset values: out_valid=0, out_data=0, out_ch=0, sel_err=0, scan pointer ptr=0, mode_q=0.
- Current channel:
  - cur = sel when mode=0.
  - cur = ptr when mode=1.
- Load enable: ld = !out_valid || out_ready. The output register is free or draining this cycle.
- in_ready[i] = ld && (cur == i) && (cur < NCH). This is combinational and does not depend on in_valid. All bits are 0 when cur >= NCH.
- Input transfer: in_valid[cur] && in_ready[cur]. On an input transfer the next edge sets:
  - out_data <= channel cur data
  - out_ch <= cur
  - out_valid <= 1
  - Latency from input transfer to out_valid is 1 cycle.
- If ld and no input transfer: out_valid <= 0; out_data and out_ch hold their values.
- If !ld (stall): out_valid, out_data and out_ch hold; all in_ready are 0.
- Back-to-back: a stalled output with out_ready=1 and a new input transfer in the same cycle sustains one word per cycle.
- Out-of-range select:
  - Only possible when mode=0 and NCH is not a power of two.
  - sel >= NCH with ld=1 gives sel_err=1 for that cycle (registered, visible the next cycle), no transfer, and out_valid <= 0.
- Scan pointer:
  - ptr advances on every input transfer while mode=1, with wrap NCH-1 -> 0.
  - Base build: ptr holds while in_valid[ptr]=0 (strict TDM slot; the slot waits for its channel).
  - ptr holds while mode=0.
- Mode change:
  - mode_q is the registered previous mode.
  - A 0->1 transition (mode=1, mode_q=0) forces ptr to 0 on that edge. cur uses ptr=0 in that cycle.
  - A 1->0 transition takes effect immediately through cur=sel.
  - A word already in the output register is never dropped or altered by a mode change.
- Reset mid-operation: a held word is discarded (out_valid=0) and ptr returns to 0. No in_ready is asserted during the reset cycle.

Optional Feature:
Macro TDM_MUX_SKIP_EN.
- Defined: in scan mode, ptr also advances (+1, wrap) when ld=1 and in_valid[ptr]=0. Idle channels are skipped at one channel per cycle, giving a work-conserving round-robin.
- Undefined: ptr advances only on a transfer (strict slotting).
- Manual mode is identical in both builds.

Decomposition:
- Package tdm_mux_pkg:
  - mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1
  - a function returning the next wrapped index for a given NCH
- One sub-module, tdm_mux_ptr: the scan pointer register with advance, wrap, restart-on-mode-entry and the optional skip logic.
- The top level holds the select/ld/ready logic and the output register.

Test Plan:
- Reset, then mode=0, sel=5, in_valid=16'h0020, ch5=8'hA5, out_ready=1 -> in_ready=16'h0020; next cycle out_valid=1, out_data=A5, out_ch=5.
- Stall: out_valid=1, out_ready=0 for 3 cycles while channel data changes -> out_data stable, in_ready=0. Then out_ready=1 -> new word loaded the same cycle, no bubble.
- Scan mode, all in_valid=1, ch i data=i+8'h10, out_ready=1 -> out_ch sequence 0,1,...,15,0 on consecutive cycles; data 10..1F.
- Scan mode, base build, in_valid=16'h0009 -> ptr stops at 1 and out_valid drops. With TDM_MUX_SKIP_EN -> out_ch alternates 0,3,0,3, with gap cycles while skipping.
- NCH=12, mode=0, sel=13 -> in_ready=0, sel_err pulses one cycle, out_valid=0.
- Mid-scan: switch mode 1->0->1, and assert rst_n=0 for 1 cycle mid-stream -> after 0->1 first out_ch=0; after reset out_valid=0, ptr=0, and the first post-reset word is from ch0.
